umi_fifo_sync: RTL
==================

# umi_fifo_sync

Single-clock, parametrised UMI packet FIFO: the same-clock-domain successor to the dual-clock UMI FIFO, used for rate decoupling between UMI pipeline stages. It adds generic width and depth, an occupancy count, a programmable almost-full flag, a synchronous flush and deterministic LFSR-driven chaos pushback. A bypass mode turns the block into a wire.

## Interface

Parameters:

- DW, 256, UMI packet width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.
- SEED, 16'hACE1, chaos LFSR reset value; must be nonzero.

Ports:

- clk, input, 1, single clock for all logic.
- nreset, input, 1, asynchronous active-low reset; all state is cleared on assertion and released synchronously.
- bypass, input, 1, 1 = combinational pass-through; storage is frozen.
- chaosmode, input, 1, 1 = pseudo-random input pushback.
- flush, input, 1, synchronous clear of all stored entries.
- afull_thresh, input, AW+1, almost-full threshold.
- fifo_count, output, AW+1, number of stored entries, 0..DEPTH.
- fifo_full, output, 1, count == DEPTH.
- fifo_empty, output, 1, count == 0.
- fifo_afull, output, 1, count >= afull_thresh.
- umi_in_valid, input, 1, input valid.
- umi_in_packet, input, DW, input packet.
- umi_in_ready, output, 1, input ready.
- umi_out_valid, output, 1, output valid.
- umi_out_packet, output, DW, output packet.
- umi_out_ready, input, 1, output ready.

## Operation

Reset values:

- fifo_count = 0, fifo_empty = 1, fifo_full = 0.
- fifo_afull = (afull_thresh == 0).
- umi_out_valid = 0.
- Pointers = 0, LFSR = SEED.
- Storage contents are not reset; umi_out_packet is don't-care while umi_out_valid = 0.

Handshake rules:

- Valid/ready handshake; a transfer happens on a clock edge where valid & ready.
- umi_in_ready = ~fifo_full & ~flush & ~(chaosmode & lfsr[0]).
- umi_out_valid = ~fifo_empty & ~flush.
- umi_out_packet = mem[rd_ptr] (first-word fall-through from flop storage).

Data path:

- push = umi_in_valid & umi_in_ready; writes mem[wr_ptr], wr_ptr++.
- pop = umi_out_valid & umi_out_ready; rd_ptr++.
- Pointers are AW bits and wrap modulo DEPTH.
- Count is AW+1 bits: +1 on push only, -1 on pop only, unchanged on both.

Flush:

- While flush = 1: pointers and count are cleared to 0 and no push or pop occurs.
- Flush has priority over all other activity.

Chaos LFSR:

- 16-bit Fibonacci LFSR, taps 16,14,13,11.
- Advances every cycle while chaosmode = 1; holds otherwise.
- Never loads zero.

Bypass:

- umi_out_valid = umi_in_valid, umi_out_packet = umi_in_packet, umi_in_ready = umi_out_ready.
- No push or pop occurs; count and pointers hold; status outputs reflect frozen storage.
- Entries stored before bypass is asserted are kept and drain after bypass is released.

Boundary conditions:

- Full with umi_in_valid = 1: no write, data is held upstream.
- Full with a pop: count becomes DEPTH-1 and ready rises the next cycle. There is no same-cycle refill at full.
- Empty with umi_in_valid = 1: no read this cycle. The packet appears the next cycle.
- Push and pop together at 0 < count < DEPTH: count is unchanged and both pointers advance.
- afull_thresh > DEPTH: fifo_afull never asserts.
- nreset asserted mid-transfer: all stored packets are discarded immediately.

## Timing

- Write-to-read latency is 1 cycle: a packet pushed at edge N gives umi_out_valid = 1 after edge N.
- All status outputs are registered-state decodes and update on the same edge as the push or pop.
- umi_in_ready depends combinationally only on state, flush and chaosmode. It never depends on umi_in_valid.
- Bypass path: combinational, 0 cycles.
- Throughput: one packet per cycle in steady state (chaos off, 0 < count < DEPTH).

## Structure

- Package umi_fifo_pkg holds LFSR_W = 16, the LFSR tap mask and the default SEED. These are shared with the dual-clock FIFO chaos logic.
- One sub-module, umi_fifo_lfsr, contains the LFSR with inputs clk, nreset, en and output lfsr[15:0].
- Storage is an inline flop array, DEPTH x DW. No memory macro is used.

## Test plan

- Reset, then 4 pushes (0xA0..0xA3) with umi_out_ready = 0, DEPTH = 4 -> fifo_full = 1, fifo_count = 4, umi_in_ready = 0; a 5th push is not accepted.
- Drain at one pop per cycle -> outputs 0xA0, 0xA1, 0xA2, 0xA3 in order; fifo_empty = 1 after the 4th pop.
- Continuous push and pop for 20 cycles starting at count = 2 -> count stays 2, pointers wrap 5 times, data order is preserved.
- afull_thresh = 3: push 3 packets -> fifo_afull asserts on the edge of the 3rd push and deasserts on the first pop.
- Count = 3, assert flush for 1 cycle while umi_in_valid = 1 -> no write, count = 0, umi_out_valid = 0 the next cycle.
- chaosmode = 1, umi_out_ready = 1, 1000 cycles of random valid -> umi_in_ready low on 40-60% of cycles, and the scoreboard matches with no loss. Then bypass = 1 -> umi_out_packet equals umi_in_packet in the same cycle and count is frozen.

Source files
------------

// File: rtl/umi_fifo_pkg.sv
// umi_fifo_pkg: constants shared by the UMI FIFO family.
// Chaos LFSR width, tap mask and default seed.
package umi_fifo_pkg;

  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] cur
  );
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {cur[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/umi_fifo_lfsr.sv
// umi_fifo_lfsr: 16-bit Fibonacci LFSR for chaos pushback.
// Advances while en is high, holds otherwise.
module umi_fifo_lfsr
  import umi_fifo_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] nxt;

  // Zero is a lock-up state; fall back to the seed if ever reached.
  always_comb begin
    nxt = lfsr_next(lfsr);
    if (nxt == '0)
      nxt = SEED;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      lfsr <= SEED;
    else if (en)
      lfsr <= nxt;
  end

endmodule

// File: rtl/umi_fifo_sync.sv
// umi_fifo_sync: single-clock UMI packet FIFO with flush,
// almost-full flag, chaos pushback and bypass.
module umi_fifo_sync
  import umi_fifo_pkg::*;
#(
  parameter int DW    = 256,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          bypass,
  input  logic          chaosmode,
  input  logic          flush,
  input  logic [AW:0]   afull_thresh,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_afull,
  input  logic          umi_in_valid,
  input  logic [DW-1:0] umi_in_packet,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [DW-1:0] umi_out_packet,
  input  logic          umi_out_ready
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;
  logic              stall;
  logic              q_ready;
  logic              q_valid;
  logic              push;
  logic              pop;

  umi_fifo_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .nreset (nreset),
    .en     (chaosmode),
    .lfsr   (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:1];

  assign fifo_count = count;
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign fifo_afull = (count >= afull_thresh);

  assign stall   = chaosmode & lfsr[0];
  assign q_ready = ~fifo_full & ~flush & ~stall;
  assign q_valid = ~fifo_empty & ~flush;

  // Bypass turns the block into a wire; storage is frozen.
  assign umi_in_ready   = bypass ? umi_out_ready : q_ready;
  assign umi_out_valid  = bypass ? umi_in_valid  : q_valid;
  assign umi_out_packet = bypass ? umi_in_packet : mem[rd_ptr];

  assign push = ~bypass & umi_in_valid & q_ready;
  assign pop  = ~bypass & q_valid & umi_out_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= umi_in_packet;
  end

endmodule
